// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scan_ctrl
// Brief   : 4x3 matrix keypad scanner with frame-based debounce and key encoder.
// Revision: 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 20
) (
  input  logic       clk,
  input  logic       reset_1,
  output logic [3:0] Row,
  input  logic [2:0] Col,
  output logic [3:0] Code_1,
  output logic       Valid_1,
  output logic       key_hold
);

  localparam int c_SLOT_W = $clog2(SCAN_DIV);
  localparam int c_DEB_W  = $clog2(DEB_FRAMES + 1);

  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_DIV - 1);
  localparam logic [c_SLOT_W-1:0] c_SLOT_ONE  = c_SLOT_W'(1);
  localparam logic [c_DEB_W-1:0]  c_DEB_MAX   = c_DEB_W'(DEB_FRAMES);
  localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  logic [2:0]          r_col_s1;
  logic [2:0]          r_col_s2;
  logic [c_SLOT_W-1:0] r_slot;
  logic [1:0]          r_row_idx;
  logic [3:0]          r_row;
  logic [1:0]          r_acc_cnt;
  logic [3:0]          r_acc_code;
  state_t              r_state;
  logic [c_DEB_W-1:0]  r_deb;
  logic [3:0]          r_cand;
  logic [3:0]          r_code;
  logic                r_valid;
  logic                r_key_hold;

  logic                w_slot_end;
  logic                w_frame_end;
  logic [2:0]          w_col_act;
  logic [1:0]          w_hits;
  logic [1:0]          w_col_idx;
  logic [2:0]          w_tot;
  logic [1:0]          w_cnt_sat;
  logic [3:0]          w_frame_code;
  logic                w_res_none;
  logic                w_res_single;
  logic [c_DEB_W-1:0]  w_deb_inc;
  state_t              w_state_nxt;
  logic [c_DEB_W-1:0]  w_deb_nxt;
  logic [3:0]          w_cand_nxt;
  logic [3:0]          w_code_nxt;
  logic                w_valid_nxt;

  function automatic logic [3:0] f_key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'b0001;
      4'b00_01: code = 4'b0010;
      4'b00_10: code = 4'b0011;
      4'b01_00: code = 4'b0100;
      4'b01_01: code = 4'b0101;
      4'b01_10: code = 4'b0110;
      4'b10_00: code = 4'b0111;
      4'b10_01: code = 4'b1000;
      4'b10_10: code = 4'b1001;
      4'b11_00: code = 4'b1011;
      4'b11_01: code = 4'b0000;
      4'b11_10: code = 4'b1010;
      default:  code = 4'b0000;
    endcase
    return code;
  endfunction

  // Col is asynchronous to clk; idle (released) level is all ones.
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      r_col_s1 <= 3'b111;
      r_col_s2 <= 3'b111;
    end else begin
      r_col_s1 <= Col;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_slot_end  = (r_slot == c_SLOT_LAST);
  assign w_frame_end = w_slot_end && (r_row_idx == 2'd3);

  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      r_slot    <= '0;
      r_row_idx <= 2'd0;
      r_row     <= 4'b1110;
    end else if (w_slot_end) begin
      r_slot    <= '0;
      r_row_idx <= r_row_idx + 2'd1;
      r_row     <= {r_row[2:0], r_row[3]};
    end else begin
      r_slot    <= r_slot + c_SLOT_ONE;
    end
  end

  assign w_col_act = ~r_col_s2;
  assign w_hits    = {1'b0, w_col_act[0]} + {1'b0, w_col_act[1]} + {1'b0, w_col_act[2]};
  assign w_col_idx = w_col_act[0] ? 2'd0 : (w_col_act[1] ? 2'd1 : 2'd2);
  assign w_tot     = {1'b0, r_acc_cnt} + {1'b0, w_hits};
  // Key count saturates at 2: anything above one key in a frame is MULTI.
  assign w_cnt_sat    = (w_tot > 3'd1) ? 2'd2 : w_tot[1:0];
  assign w_frame_code = (w_hits == 2'd1) ? f_key_code(r_row_idx, w_col_idx) : r_acc_code;
  assign w_res_none   = (w_cnt_sat == 2'd0);
  assign w_res_single = (w_cnt_sat == 2'd1);

  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_frame_end) begin
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_slot_end) begin
      r_acc_cnt  <= w_cnt_sat;
      r_acc_code <= w_frame_code;
    end
  end

  assign w_deb_inc = (r_deb == c_DEB_MAX) ? r_deb : r_deb + c_DEB_ONE;

  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      r_state    <= S_IDLE;
      r_deb      <= '0;
      r_cand     <= 4'd0;
      r_code     <= 4'd0;
      r_valid    <= 1'b0;
      r_key_hold <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_deb      <= w_deb_nxt;
      r_cand     <= w_cand_nxt;
      r_code     <= w_code_nxt;
      r_valid    <= w_valid_nxt;
      r_key_hold <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb;
    w_cand_nxt  = r_cand;
    w_code_nxt  = r_code;
    w_valid_nxt = r_valid;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_res_single) begin
            w_cand_nxt  = w_frame_code;
            w_deb_nxt   = c_DEB_ONE;
            w_state_nxt = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (w_res_single && (w_frame_code == r_cand)) begin
            if (w_deb_inc == c_DEB_MAX) begin
              w_code_nxt  = r_cand;
              w_valid_nxt = 1'b1;
              w_deb_nxt   = '0;
              w_state_nxt = S_PRESSED;
            end else begin
              w_deb_nxt   = w_deb_inc;
            end
          end else begin
            w_deb_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
        S_PRESSED: begin
          // Extra or different keys while held are ignored until a clean release.
          if (w_res_none) begin
            w_deb_nxt   = c_DEB_ONE;
            w_state_nxt = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_res_none) begin
            if (w_deb_inc == c_DEB_MAX) begin
              w_valid_nxt = 1'b0;
              w_deb_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_deb_nxt   = w_deb_inc;
            end
          end else begin
            w_deb_nxt   = '0;
            w_state_nxt = S_PRESSED;
          end
        end
        default: begin
          w_deb_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign Row      = r_row;
  assign Code_1   = r_code;
  assign Valid_1  = r_valid;
  assign key_hold = r_key_hold;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_scan_ctrl
// Brief   : Directed + random keypad stimulus against a frame-level key model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DF = 3;

  logic        clk = 1'b0;
  logic        reset_1 = 1'b0;
  logic [3:0]  Row;
  logic [2:0]  Col;
  logic [3:0]  Code_1;
  logic        Valid_1;
  logic        key_hold;
  logic [11:0] keys = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rises = 0;
  int falls = 0;
  logic [3:0] rise_code = 4'd0;
  logic prev_valid = 1'b0;

  // Reference model state: frame-level view of the keypad rules.
  logic [3:0]  key_tab [12];
  int          m_edge;
  logic [11:0] m_k1, m_k2;
  int          m_nkeys;
  logic [3:0]  m_fcode;
  logic        m_valid;
  logic [3:0]  m_code, m_cand;
  int          m_run, m_quiet;

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    Col = 3'b111;
    for (int r = 0; r < 4; r++)
      if (!Row[r]) Col = Col & ~keys[r*3 +: 3];
  end

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEB_FRAMES(DF)) dut (
    .clk      (clk),
    .reset_1  (reset_1),
    .Row      (Row),
    .Col      (Col),
    .Code_1   (Code_1),
    .Valid_1  (Valid_1),
    .key_hold (key_hold)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_edge = 0; m_k1 = '0; m_k2 = '0; m_nkeys = 0; m_fcode = 4'd0;
    m_valid = 1'b0; m_code = 4'd0; m_cand = 4'd0; m_run = 0; m_quiet = 0;
  endtask

  task automatic frame_eval();
    logic none, single;
    none   = (m_nkeys == 0);
    single = (m_nkeys == 1);
    if (!m_valid) begin
      if (m_run > 0 && !(single && m_fcode == m_cand)) m_run = 0;
      else if (single) begin
        if (m_run == 0) m_cand = m_fcode;
        m_run++;
        if (m_run == DF) begin m_valid = 1'b1; m_code = m_cand; m_run = 0; end
      end
    end else begin
      m_quiet = none ? m_quiet + 1 : 0;
      if (m_quiet == DF) begin m_valid = 1'b0; m_quiet = 0; end
    end
  endtask

  // Each row's sample is taken on its slot's last edge and sees keys two edges earlier.
  task automatic model_edge();
    int slot, row;
    slot = m_edge % SD;
    row  = (m_edge / SD) % 4;
    if (slot == SD - 1) begin
      for (int c = 0; c < 3; c++)
        if (m_k2[row*3 + c]) begin m_nkeys++; m_fcode = key_tab[row*3 + c]; end
      if (row == 3) begin frame_eval(); m_nkeys = 0; end
    end
    m_k2 = m_k1;
    m_k1 = keys;
    m_edge++;
  endtask

  task automatic step();
    logic [3:0] exp_row;
    @(posedge clk);
    if (reset_1) model_edge();
    @(negedge clk);
    cyc++;
    exp_row = ~(4'b0001 << ((m_edge / SD) % 4));
    chk("row", 32'(Row), 32'(exp_row));
    chk("valid", 32'(Valid_1), 32'(m_valid));
    chk("key_hold", 32'(key_hold), 32'(m_valid));
    chk("code", 32'(Code_1), 32'(m_code));
    if (Valid_1 && !prev_valid) begin rises++; rise_code = Code_1; end
    if (!Valid_1 && prev_valid) falls++;
    prev_valid = Valid_1;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic wait_valid(input logic level, input int budget, output int took);
    int t0;
    t0 = cyc;
    took = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (Valid_1 === level) begin took = cyc - t0; break; end
    end
  endtask

  initial begin
    int took, r0, f0, sel;
    key_tab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd0, 4'd10};
    m_reset();

    // 1: reset and idle scanning
    hold(3);
    chk("rst_row", 32'(Row), 32'h0000000e);
    chk("rst_code", 32'(Code_1), 32'h0);
    reset_1 = 1'b1;
    hold(40);

    // 2: key "2" press/release latency
    r0 = rises;
    keys = 12'b1 << 1;
    wait_valid(1'b1, 100, took);
    chk("s2_rise_lat_ok", 32'(took >= 1 && took <= 67), 32'd1);
    chk("s2_rise_code", 32'(rise_code), 32'h2);
    hold(200 - ((took < 0) ? 100 : took));
    keys = '0;
    wait_valid(1'b0, 100, took);
    // Measured from the last edge with the key still seen; the edge after release is +1.
    chk("s2_fall_lat_ok", 32'(took >= 47 && took <= 67), 32'd1);
    chk("s2_one_rise", 32'(rises - r0), 32'd1);
    hold(20);

    // 3: "#" held, "*" added, "#" released while "*" remains
    r0 = rises;
    keys = 12'b1 << 11;
    hold(100);
    keys = keys | (12'b1 << 9);
    hold(100);
    keys = 12'b1 << 9;
    hold(60);
    chk("s3_code", 32'(Code_1), 32'ha);
    chk("s3_valid", 32'(Valid_1), 32'd1);
    chk("s3_one_rise", 32'(rises - r0), 32'd1);
    keys = '0;
    hold(80);

    // 4: bouncing press and release of "7"
    r0 = rises; f0 = falls;
    for (int i = 0; i < 8; i++) begin keys = keys ^ (12'b1 << 6); hold(5); end
    keys = 12'b1 << 6;
    hold(150);
    chk("s4_one_rise", 32'(rises - r0), 32'd1);
    chk("s4_code", 32'(Code_1), 32'h7);
    for (int i = 0; i < 6; i++) begin keys = keys ^ (12'b1 << 6); hold(5); end
    keys = '0;
    hold(100);
    chk("s4_one_fall", 32'(falls - f0), 32'd1);

    // 5: two keys together, then a one-frame tap
    r0 = rises;
    keys = (12'b1 << 0) | (12'b1 << 4);
    hold(200);
    keys = '0;
    hold(40);
    keys = 12'b1 << 8;
    hold(16);
    keys = '0;
    hold(100);
    chk("s5_no_rise", 32'(rises - r0), 32'd0);
    chk("s5_code_kept", 32'(Code_1), 32'h7);

    // 6: asynchronous reset while pressed, then re-accept
    keys = 12'b1 << 4;
    hold(80);
    chk("s6_pre_valid", 32'(Valid_1), 32'd1);
    #2 reset_1 = 1'b0;
    #1;
    chk("s6_rst_valid", 32'(Valid_1), 32'd0);
    chk("s6_rst_hold", 32'(key_hold), 32'd0);
    chk("s6_rst_code", 32'(Code_1), 32'd0);
    chk("s6_rst_row", 32'(Row), 32'h0000000e);
    m_reset();
    prev_valid = 1'b0;
    hold(3);
    reset_1 = 1'b1;
    r0 = rises;
    hold(80);
    chk("s6_reaccept", 32'(rises - r0), 32'd1);
    chk("s6_code", 32'(Code_1), 32'h5);
    keys = '0;
    hold(80);

    // Random key patterns, held for random lengths
    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) keys = '0;
      else if (sel == 3) keys = (12'b1 << $urandom_range(0, 11)) | (12'b1 << $urandom_range(0, 11));
      else keys = 12'b1 << $urandom_range(0, 11);
      hold(int'($urandom_range(1, 90)));
    end
    keys = '0;
    hold(100);
    chk("end_idle", 32'(Valid_1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
